ram_sync_clr: RTL and testbench

Parametrised synchronous single-port RAM with a built-in clear sequencer; the registered-read successor to the team's asynchronous-read `cs`/`wr` RAM. After every reset, and on request, it zero-fills the array. Reads are registered and flagged by `rd_valid`, and `busy` tells the requester when accesses are refused. It sits between a bus-side requester and local storage wherever deterministic power-up contents are required.

---
 rtl/ram_pkg.sv | 13 +
 rtl/ram_clear_seq.sv | 55 +++++
 rtl/ram_sync_clr.sv | 84 ++++++++
 tb/tb_ram_sync_clr.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and default geometry for the synchronous RAM with clear sequencer.
package ram_pkg;

    localparam int DEF_ADDR_SIZE   = 10;
    localparam int DEF_WORD_SIZE   = 8;
    localparam int DEF_MEMORY_SIZE = 1024;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } ram_state_t;

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: sweeps every word to zero after reset and on an accepted request.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int ADDR_SIZE   = DEF_ADDR_SIZE,
    parameter int MEMORY_SIZE = DEF_MEMORY_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_req,
    output logic                 busy,
    output logic                 clr_we,
    output logic [ADDR_SIZE-1:0] clr_addr
);

    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEMORY_SIZE - 1);

    ram_state_t           state_q, state_d;
    logic [ADDR_SIZE-1:0] ptr_q, ptr_d;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            CLEAR: begin
                if (ptr_q == LAST_ADDR) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + ADDR_SIZE'(1);
                end
            end
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign busy     = (state_q == CLEAR);
    assign clr_we   = busy;
    assign clr_addr = ptr_q;

endmodule

// File: rtl/ram_sync_clr.sv
// Single-port RAM with registered read, rd_valid flag and a zero-fill sweep after reset or clr_req.
module ram_sync_clr
    import ram_pkg::*;
#(
    parameter int ADDR_SIZE   = DEF_ADDR_SIZE,
    parameter int WORD_SIZE   = DEF_WORD_SIZE,
    parameter int MEMORY_SIZE = DEF_MEMORY_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cs,
    input  logic                 wr,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [WORD_SIZE-1:0] data_in,
    input  logic                 clr_req,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 rd_valid,
    output logic                 busy
);

    localparam logic [ADDR_SIZE:0] MEM_WORDS = (ADDR_SIZE + 1)'(MEMORY_SIZE);

    logic                 seq_busy;
    logic                 clr_we;
    logic [ADDR_SIZE-1:0] clr_addr;

    logic [WORD_SIZE-1:0] mem [0:MEMORY_SIZE-1];

    logic                 in_range;
    logic                 accept;
    logic                 user_we;
    logic                 rd_en;
    logic [WORD_SIZE-1:0] data_out_q, data_out_d;
    logic                 rd_valid_q, rd_valid_d;

    ram_clear_seq #(
        .ADDR_SIZE   (ADDR_SIZE),
        .MEMORY_SIZE (MEMORY_SIZE)
    ) u_clear_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .busy     (seq_busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // A clear request outranks any user access presented in the same cycle.
    assign in_range = ({1'b0, addr} < MEM_WORDS);
    assign accept   = cs && !seq_busy && !clr_req;
    assign user_we  = accept && wr && in_range;
    assign rd_en    = accept && !wr;

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (user_we) begin
            mem[addr] <= data_in;
        end
    end

    always_comb begin
        data_out_d = data_out_q;
        rd_valid_d = rd_en;
        if (rd_en) begin
            data_out_d = in_range ? mem[addr] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;
    assign busy     = seq_busy;

endmodule

// File: tb/tb_ram_sync_clr.sv
// Randomised self-checking bench: a full-depth and a partial-depth instance against a behavioural model.
module tb_ram_sync_clr;

    localparam int AW = 10;
    localparam int DW = 8;
    localparam int D0 = 1024;
    localparam int D1 = 1000;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          cs      = 1'b0;
    logic          wr      = 1'b0;
    logic          clr_req = 1'b0;
    logic [AW-1:0] addr    = '0;
    logic [DW-1:0] data_in = '0;

    logic [DW-1:0] dout0, dout1;
    logic          vld0, vld1, busy0, busy1;

    always #5 clk = ~clk;

    ram_sync_clr #(
        .ADDR_SIZE   (AW),
        .WORD_SIZE   (DW),
        .MEMORY_SIZE (D0)
    ) u_dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .cs       (cs),
        .wr       (wr),
        .addr     (addr),
        .data_in  (data_in),
        .clr_req  (clr_req),
        .data_out (dout0),
        .rd_valid (vld0),
        .busy     (busy0)
    );

    ram_sync_clr #(
        .ADDR_SIZE   (AW),
        .WORD_SIZE   (DW),
        .MEMORY_SIZE (D1)
    ) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .cs       (cs),
        .wr       (wr),
        .addr     (addr),
        .data_in  (data_in),
        .clr_req  (clr_req),
        .data_out (dout1),
        .rd_valid (vld1),
        .busy     (busy1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: remaining sweep cycles, contents and output registers per instance.
    int            dep   [2];
    int            rem   [2];
    logic [DW-1:0] mref  [2][1024];
    logic [DW-1:0] mdout [2];
    logic          mvld  [2];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_zero(input int k);
        for (int i = 0; i < 1024; i++) mref[k][i] = '0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            rem[k]   = dep[k];
            mdout[k] = '0;
            mvld[k]  = 1'b0;
            model_zero(k);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (rem[k] > 0) begin
                rem[k]  = rem[k] - 1;
                mvld[k] = 1'b0;
            end else if (clr_req) begin
                rem[k]  = dep[k];
                mvld[k] = 1'b0;
                model_zero(k);
            end else if (cs && wr) begin
                if (int'(addr) < dep[k]) mref[k][addr] = data_in;
                mvld[k] = 1'b0;
            end else if (cs) begin
                mdout[k] = (int'(addr) < dep[k]) ? mref[k][addr] : '0;
                mvld[k]  = 1'b1;
            end else begin
                mvld[k] = 1'b0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, "/busy0"}, 32'(busy0), 32'(rem[0] > 0));
        check_eq({tag, "/vld0"},  32'(vld0),  32'(mvld[0]));
        check_eq({tag, "/dout0"}, 32'(dout0), 32'(mdout[0]));
        check_eq({tag, "/busy1"}, 32'(busy1), 32'(rem[1] > 0));
        check_eq({tag, "/vld1"},  32'(vld1),  32'(mvld[1]));
        check_eq({tag, "/dout1"}, 32'(dout1), 32'(mdout[1]));
    endtask

    task automatic drive(input logic c, input logic w, input int a, input int d, input logic clr);
        cs      = c;
        wr      = w;
        addr    = AW'(a);
        data_in = DW'(d);
        clr_req = clr;
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic drive_random();
        int a;
        a = ($urandom % 8 == 0) ? int'($urandom_range(990, 1023)) : int'($urandom_range(0, 31));
        drive(($urandom % 4) != 0, $urandom % 2 == 1, a, int'($urandom % 256), ($urandom % 300) == 0);
    endtask

    // Counts cycles until busy0 falls, bounded so a stuck sequencer cannot hang the run.
    task automatic wait_clear(input string tag, output int cnt);
        cnt = 0;
        while (busy0 && cnt < 3000) begin
            cycle(tag);
            cnt++;
        end
    endtask

    int cnt;

    initial begin
        dep[0] = D0;
        dep[1] = D1;

        rst_n = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Writes attempted throughout the power-up sweep must be ignored by the full-depth instance.
        drive(1'b1, 1'b1, 7, 8'hFF, 1'b0);
        wait_clear("lockout", cnt);
        check_eq("clear_len_reset", 32'(cnt), 32'(D0));

        drive(1'b1, 1'b0, 7, 0, 1'b0);
        cycle("read7");
        check_eq("read7_d0", 32'(dout0), 32'h00);
        check_eq("read7_vld", 32'(vld0), 32'h1);
        check_eq("read7_d1", 32'(dout1), 32'hFF);

        drive(1'b1, 1'b0, 5, 0, 1'b0);
        cycle("read5");
        check_eq("read5_d0", 32'(dout0), 32'h00);

        drive(1'b1, 1'b1, 3, 8'hAA, 1'b0);    cycle("wr3");
        drive(1'b1, 1'b1, 1023, 8'h55, 1'b0); cycle("wr1023");
        drive(1'b1, 1'b0, 3, 0, 1'b0);        cycle("rd3");
        check_eq("rd3_d0", 32'(dout0), 32'hAA);
        check_eq("rd3_vld", 32'(vld0), 32'h1);
        drive(1'b1, 1'b0, 1023, 0, 1'b0);     cycle("rd1023");
        check_eq("rd1023_d0", 32'(dout0), 32'h55);
        check_eq("rd1023_vld", 32'(vld0), 32'h1);
        check_eq("rd1023_d1_oor", 32'(dout1), 32'h00);
        drive(1'b0, 1'b0, 0, 0, 1'b0);        cycle("idle");
        check_eq("idle_vld", 32'(vld0), 32'h0);

        drive(1'b1, 1'b1, 10, 8'h12, 1'b0);   cycle("wr10");
        drive(1'b1, 1'b0, 3, 0, 1'b0);        cycle("rd3b");
        drive(1'b1, 1'b1, 10, 8'h34, 1'b1);   cycle("clrreq");
        check_eq("clr_busy_rise", 32'(busy0), 32'h1);
        drive(1'b0, 1'b0, 0, 0, 1'b0);
        wait_clear("clrsweep", cnt);
        check_eq("clear_len_req", 32'(cnt), 32'(D0));
        check_eq("dout_hold", 32'(dout0), 32'hAA);
        drive(1'b1, 1'b0, 10, 0, 1'b0);       cycle("rd10");
        check_eq("rd10_d0", 32'(dout0), 32'h00);

        drive(1'b1, 1'b1, 999, 8'h3C, 1'b0);  cycle("wr999");
        drive(1'b1, 1'b1, 1010, 8'h77, 1'b0); cycle("wr1010");
        drive(1'b1, 1'b0, 1010, 0, 1'b0);     cycle("rd1010");
        check_eq("rd1010_d1", 32'(dout1), 32'h00);
        check_eq("rd1010_vld1", 32'(vld1), 32'h1);
        check_eq("rd1010_d0", 32'(dout0), 32'h77);
        drive(1'b1, 1'b0, 999, 0, 1'b0);      cycle("rd999");
        check_eq("rd999_d1", 32'(dout1), 32'h3C);

        for (int i = 0; i < 3000; i++) begin
            drive_random();
            cycle("rand1");
        end

        drive(1'b0, 1'b0, 0, 0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("reset2");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 500; i++) begin
            drive_random();
            cycle("sweep500");
        end
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("midreset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 7, 8'hEE, 1'b0);
        wait_clear("resweep", cnt);
        check_eq("clear_len_midreset", 32'(cnt), 32'(D0));

        for (int i = 0; i < 1000; i++) begin
            drive_random();
            cycle("rand2");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
